// File: rtl/instr_loader.sv
// Boot-loader front end: receives a length-prefixed byte stream, assembles big-endian 32-bit
// instructions, pulses them into instruction memory and holds the CPU in reset until done.
module instr_loader #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned CW        = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  input  logic          rearm,
  output logic          instr_WE,
  output logic [31:0]   instr_WD,
  output logic          cpu_rstn,
  output logic          load_done,
  output logic          load_err,
  output logic [CW-1:0] words_loaded
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StLenHi,
    StLenLo,
    StLoad,
    StWrite,
    StRun,
    StErr
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [1:0]    lane_q, lane_d;
  logic [23:0]   shift_q, shift_d;
  logic [31:0]   wd_q, wd_d;
  logic [CW-1:0] words_q, words_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ready_q, ready_d;
  logic          we_q, we_d;
  logic          rstn_q, rstn_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          accept;
  logic          tmo_hit;
  logic [15:0]   hdr;

  // ready_q rather than the state drives the handshake so nothing is accepted during reset.
  assign accept  = byte_valid && ready_q;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
  assign hdr     = {count_q[15:8], byte_data};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StLenHi;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StLenHi: begin
        if (accept) state_d = StLenLo;
      end
      StLenLo: begin
        if (accept) begin
          if (hdr == 16'd0) begin
            state_d = StRun;
          end else if (32'(hdr) > MEM_DEPTH) begin
            state_d = StErr;
          end else begin
            state_d = StLoad;
          end
        end else if (tmo_hit) begin
          state_d = StErr;
        end
      end
      StLoad: begin
        if (accept) begin
          if (lane_q == 2'd3) state_d = StWrite;
        end else if (tmo_hit) begin
          state_d = StErr;
        end
      end
      StWrite: begin
        state_d = (16'(words_q) + 16'd1 == count_q) ? StRun : StLoad;
      end
      StRun, StErr: begin
        if (rearm) state_d = StLenHi;
      end
      default: state_d = StLenHi;
    endcase
  end

  // Registered outputs are derived from the upcoming state.
  always_comb begin
    ready_d = (state_d == StLenHi) || (state_d == StLenLo) || (state_d == StLoad);
    we_d    = (state_d == StWrite);
    rstn_d  = (state_d == StRun);
    done_d  = (state_d == StRun);
    err_d   = (state_d == StErr);
  end

  // Datapath next-state
  always_comb begin
    count_d = count_q;
    lane_d  = lane_q;
    shift_d = shift_q;
    wd_d    = wd_q;
    words_d = words_q;
    case (state_q)
      StLenHi: begin
        if (accept) count_d[15:8] = byte_data;
      end
      StLenLo: begin
        if (accept) count_d[7:0] = byte_data;
      end
      StLoad: begin
        if (accept) begin
          lane_d  = lane_q + 2'd1;
          shift_d = {shift_q[15:0], byte_data};
          if (lane_q == 2'd3) wd_d = {shift_q, byte_data};
        end
      end
      StWrite: begin
        words_d = words_q + CW'(1);
        lane_d  = 2'd0;
      end
      StRun, StErr: begin
        if (rearm) begin
          count_d = 16'd0;
          lane_d  = 2'd0;
          words_d = '0;
        end
      end
      default: ;
    endcase

    // Idle counter: clears on any accepted byte and on every state change.
    tmo_d = '0;
    if (((state_q == StLenLo) || (state_q == StLoad)) && !accept && (state_d == state_q)) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 16'd0;
      lane_q  <= 2'd0;
      shift_q <= 24'd0;
      wd_q    <= 32'd0;
      words_q <= '0;
      tmo_q   <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      rstn_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      lane_q  <= lane_d;
      shift_q <= shift_d;
      wd_q    <= wd_d;
      words_q <= words_d;
      tmo_q   <= tmo_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      rstn_q  <= rstn_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign byte_ready   = ready_q;
  assign instr_WE     = we_q;
  assign instr_WD     = wd_q;
  assign cpu_rstn     = rstn_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: the driver queues expected writes, a monitor checks
// every instr_WE pulse for data, timing and byte_ready, and the driver checks status flags.
module tb_instr_loader;

  localparam int unsigned TIMEOUT = 1024;
  localparam int unsigned CW      = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'd0;
  logic          byte_ready;
  logic          rearm = 1'b0;
  logic          instr_WE;
  logic [31:0]   instr_WD;
  logic          cpu_rstn;
  logic          load_done;
  logic          load_err;
  logic [CW-1:0] words_loaded;

  instr_loader #(
    .MEM_DEPTH(256),
    .TIMEOUT  (TIMEOUT),
    .CW       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .rearm       (rearm),
    .instr_WE    (instr_WE),
    .instr_WD    (instr_WD),
    .cpu_rstn    (cpu_rstn),
    .load_done   (load_done),
    .load_err    (load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] wd;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write pulse must match the oldest queued word and its cycle.
  always @(negedge clk) begin
    if (!rst && instr_WE) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got WD=0x%0h expected no write", instr_WD);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_data", instr_WD, mon_e.wd);
        chk("write_cycle", cyc, mon_e.cyc);
      end
      chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, output int acc);
    int k;
    bit got;
    k   = 0;
    got = 0;
    acc = -1;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      if (byte_ready) begin
        acc = cyc;
        got = 1;
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL byte_accept: byte 0x%0h got no ready expected ready within 200 cycles", b);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    int   acc;
    exp_t e;
    for (int i = 3; i >= 0; i--) begin
      if (gaps) idle($urandom_range(0, 3));
      send_byte(w[8*i +: 8], acc);
    end
    e.wd  = w;
    e.cyc = acc + 1;
    exp_q.push_back(e);
  endtask

  task automatic header(input logic [7:0] hi, input logic [7:0] lo);
    int acc;
    send_byte(hi, acc);
    send_byte(lo, acc);
  endtask

  task automatic do_rearm();
    rearm = 1'b1;
    @(posedge clk);
    #1;
    rearm = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic rstn, input logic done,
                            input logic err, input int words);
    chk({tag, "_cpu_rstn"}, {31'd0, cpu_rstn}, {31'd0, rstn});
    chk({tag, "_load_done"}, {31'd0, load_done}, {31'd0, done});
    chk({tag, "_load_err"}, {31'd0, load_err}, {31'd0, err});
    chk({tag, "_words"}, 32'(words_loaded), 32'(words));
  endtask

  initial begin
    int acc;
    int k;

    // Reset values while held in reset
    #7;
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_we", {31'd0, instr_WE}, 32'd0);
    chk("rst_wd", instr_WD, 32'd0);
    chk_status("rst", 1'b0, 1'b0, 1'b0, 0);
    #5 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, byte_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Two words, no gaps
    header(8'h00, 8'h02);
    send_word(32'h20080005, 1'b0);
    send_word(32'h8C090004, 1'b0);
    @(negedge clk);
    chk("t1_write_cycle_rstn", {31'd0, cpu_rstn}, 32'd0);
    @(negedge clk);
    chk_status("t1_run", 1'b1, 1'b1, 1'b0, 2);
    chk("t1_pending", exp_q.size(), 0);
    do_rearm();
    chk_status("t1_rearm", 1'b0, 1'b0, 1'b0, 0);
    chk("t1_rearm_ready", {31'd0, byte_ready}, 32'd1);

    // Zero-length program goes straight to RUN
    header(8'h00, 8'h00);
    chk_status("t2_run", 1'b1, 1'b1, 1'b0, 0);
    do_rearm();

    // Oversized header
    header(8'h01, 8'h01);
    chk_status("t3_err", 1'b0, 1'b0, 1'b1, 0);
    chk("t3_err_ready", {31'd0, byte_ready}, 32'd0);
    idle(5);
    do_rearm();
    chk("t3_rearm_err", {31'd0, load_err}, 32'd0);
    chk("t3_rearm_ready", {31'd0, byte_ready}, 32'd1);

    // Timeout after a partial word, then a clean reload
    header(8'h00, 8'h01);
    send_byte(8'hAA, acc);
    send_byte(8'hBB, acc);
    k = 0;
    while (k < int'(TIMEOUT) + 20) begin
      @(negedge clk);
      k++;
      if (load_err) break;
    end
    chk("t4_timeout_cycles", k, TIMEOUT + 1);
    chk_status("t4_err", 1'b0, 1'b0, 1'b1, 0);
    @(posedge clk);
    #1;
    do_rearm();
    header(8'h00, 8'h01);
    send_word(32'h3C011001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk_status("t4_reload", 1'b1, 1'b1, 1'b0, 1);
    do_rearm();

    // Three words with gaps in byte_valid
    header(8'h00, 8'h03);
    send_word(32'h01234567, 1'b1);
    send_word(32'h89ABCDEF, 1'b1);
    send_word(32'hDEADBEEF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk_status("t5_run", 1'b1, 1'b1, 1'b0, 3);
    do_rearm();

    // Asynchronous reset in the middle of a word
    header(8'h00, 8'h02);
    send_byte(8'h11, acc);
    send_byte(8'h22, acc);
    send_byte(8'h33, acc);
    #2 rst = 1'b1;
    #1;
    chk("t6_ready", {31'd0, byte_ready}, 32'd0);
    chk("t6_we", {31'd0, instr_WE}, 32'd0);
    chk("t6_wd", instr_WD, 32'd0);
    chk_status("t6_rst", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    header(8'h00, 8'h01);
    send_word(32'h8C090004, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk_status("t6_reload", 1'b1, 1'b1, 1'b0, 1);
    chk("final_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
